// File: rtl/cpu_csr_ctl.sv
// rtl/cpu_csr_ctl.sv - CSR read-modify-write, trap entry and MRET sequencer
//
// Sits between the execute stage and the CSR register file. It accepts one
// request at a time and drives the CSR file's registered read port and its
// write port. It returns a one-cycle response and/or a PC redirect.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_*                   request handshake and fields, latched on valid&ready
//   resp_*                  CSR-op response pulse (old value, illegal flag)
//   redirect_*              PC redirect pulse for trap entry and MRET
//   mtrap_o, mret_o         one-cycle notifications to the CSR file
//   csr_read_*              CSR file read port (data returns one cycle later)
//   csr_write_*             CSR file write port

module cpu_csr_ctl #(
  parameter bit VECTORED_EN = 1'b1,
  parameter bit RO_CHECK_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_operand_i,
  input  logic        req_wr_suppress_i,
  input  logic [31:0] req_pc_i,
  input  logic [31:0] req_cause_i,
  input  logic [31:0] req_tval_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_illegal_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        mtrap_o,
  output logic        mret_o,
  output logic [11:0] csr_read_addr_o,
  output logic        csr_read_enable_o,
  input  logic [31:0] csr_read_data_i,
  output logic [11:0] csr_write_addr_o,
  output logic [31:0] csr_write_data_o,
  output logic        csr_write_enable_o
);

  localparam logic [2:0]  OP_RW   = 3'd1;
  localparam logic [2:0]  OP_RS   = 3'd2;
  localparam logic [2:0]  OP_RC   = 3'd3;
  localparam logic [2:0]  OP_TRAP = 3'd4;
  localparam logic [2:0]  OP_MRET = 3'd5;

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CSR_RD,
    S_CSR_WB,
    S_TRAP_EPC,
    S_TRAP_CAUSE,
    S_TRAP_TVAL,
    S_TRAP_DONE,
    S_MRET_RD,
    S_MRET_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_operand;
  logic        r_wr_suppress;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;

  logic        w_accept;
  logic        w_is_csr_op;
  logic        w_will_write;
  logic        w_ro_violation;
  logic        w_illegal;
  logic        w_do_write;
  logic [31:0] w_new_value;
  logic [31:0] w_mtvec_base;
  logic [31:0] w_vec_offset;
  logic [31:0] w_trap_target;

  assign w_accept = req_valid_i && (r_state == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_addr        <= '0;
      r_operand     <= '0;
      r_wr_suppress <= 1'b0;
      r_pc          <= '0;
      r_cause       <= '0;
      r_tval        <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op          <= req_op_i;
        r_addr        <= req_addr_i;
        r_operand     <= req_operand_i;
        r_wr_suppress <= req_wr_suppress_i;
        r_pc          <= req_pc_i;
        r_cause       <= req_cause_i;
        r_tval        <= req_tval_i;
      end
    end
  end

  // CSRRW always writes; CSRRS/CSRRC skip the write when rs1/zimm was zero.
  assign w_is_csr_op    = (r_op == OP_RW) || (r_op == OP_RS) || (r_op == OP_RC);
  assign w_will_write   = (r_op == OP_RW) || !r_wr_suppress;
  assign w_ro_violation = RO_CHECK_EN && (r_addr[11:10] == 2'b11) && w_will_write;
  assign w_illegal      = !w_is_csr_op || w_ro_violation;
  assign w_do_write     = w_is_csr_op && w_will_write && !w_ro_violation;

  always_comb begin
    w_new_value = r_operand;
    case (r_op)
      OP_RS:   w_new_value = csr_read_data_i | r_operand;
      OP_RC:   w_new_value = csr_read_data_i & ~r_operand;
      default: w_new_value = r_operand;
    endcase
  end

  // Vectored mode only applies to interrupts; reserved modes behave as direct.
  assign w_mtvec_base = csr_read_data_i & 32'hFFFF_FFFC;
  assign w_vec_offset = (r_cause & 32'h7FFF_FFFF) << 2;
  assign w_trap_target = (VECTORED_EN && (csr_read_data_i[1:0] == 2'b01) && r_cause[31])
                         ? (w_mtvec_base + w_vec_offset) : w_mtvec_base;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          case (req_op_i)
            OP_TRAP: w_next = S_TRAP_EPC;
            OP_MRET: w_next = S_MRET_RD;
            default: w_next = S_CSR_RD;
          endcase
        end
      end
      S_CSR_RD:     w_next = S_CSR_WB;
      S_CSR_WB:     w_next = S_IDLE;
      S_TRAP_EPC:   w_next = S_TRAP_CAUSE;
      S_TRAP_CAUSE: w_next = S_TRAP_TVAL;
      S_TRAP_TVAL:  w_next = S_TRAP_DONE;
      S_TRAP_DONE:  w_next = S_IDLE;
      S_MRET_RD:    w_next = S_MRET_DONE;
      S_MRET_DONE:  w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o        = 1'b0;
    resp_valid_o       = 1'b0;
    resp_data_o        = '0;
    resp_illegal_o     = 1'b0;
    redirect_valid_o   = 1'b0;
    redirect_pc_o      = '0;
    mtrap_o            = 1'b0;
    mret_o             = 1'b0;
    csr_read_addr_o    = '0;
    csr_read_enable_o  = 1'b0;
    csr_write_addr_o   = '0;
    csr_write_data_o   = '0;
    csr_write_enable_o = 1'b0;
    case (r_state)
      S_IDLE: req_ready_o = 1'b1;
      S_CSR_RD: begin
        // Unknown op codes keep the CSR-op timing but never touch the file.
        if (w_is_csr_op) begin
          csr_read_enable_o = 1'b1;
          csr_read_addr_o   = r_addr;
        end
      end
      S_CSR_WB: begin
        resp_valid_o   = 1'b1;
        resp_illegal_o = w_illegal;
        resp_data_o    = w_illegal ? 32'h0 : csr_read_data_i;
        if (w_do_write) begin
          csr_write_enable_o = 1'b1;
          csr_write_addr_o   = r_addr;
          csr_write_data_o   = w_new_value;
        end
      end
      S_TRAP_EPC: begin
        csr_write_enable_o = 1'b1;
        csr_write_addr_o   = ADDR_MEPC;
        csr_write_data_o   = r_pc & 32'hFFFF_FFFC;
      end
      S_TRAP_CAUSE: begin
        csr_write_enable_o = 1'b1;
        csr_write_addr_o   = ADDR_MCAUSE;
        csr_write_data_o   = r_cause;
      end
      S_TRAP_TVAL: begin
        csr_write_enable_o = 1'b1;
        csr_write_addr_o   = ADDR_MTVAL;
        csr_write_data_o   = r_tval;
        csr_read_enable_o  = 1'b1;
        csr_read_addr_o    = ADDR_MTVEC;
      end
      S_TRAP_DONE: begin
        mtrap_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = w_trap_target;
      end
      S_MRET_RD: begin
        csr_read_enable_o = 1'b1;
        csr_read_addr_o   = ADDR_MEPC;
      end
      S_MRET_DONE: begin
        mret_o           = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_read_data_i & 32'hFFFF_FFFC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_csr_ctl.sv
// tb/tb_cpu_csr_ctl.sv - self-checking bench for cpu_csr_ctl
//
// Provides a behavioural CSR register file (registered read port) and a
// reference array of CSR contents kept in step with the expected writes.

module tb_cpu_csr_ctl;

  localparam bit VEC = 1'b1;
  localparam bit ROC = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_operand;
  logic        req_wr_suppress;
  logic [31:0] req_pc;
  logic [31:0] req_cause;
  logic [31:0] req_tval;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mtrap;
  logic        mret;
  logic [11:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;

  always #5 clk = ~clk;

  cpu_csr_ctl #(.VECTORED_EN(VEC), .RO_CHECK_EN(ROC)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_operand_i(req_operand), .req_wr_suppress_i(req_wr_suppress),
    .req_pc_i(req_pc), .req_cause_i(req_cause), .req_tval_i(req_tval),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_illegal_o(resp_illegal),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .mtrap_o(mtrap), .mret_o(mret),
    .csr_read_addr_o(rd_addr), .csr_read_enable_o(rd_en), .csr_read_data_i(rd_data),
    .csr_write_addr_o(wr_addr), .csr_write_data_o(wr_data), .csr_write_enable_o(wr_en)
  );

  // Behavioural CSR file seen by the DUT.
  logic [31:0] csr_mem [0:4095];
  logic        mem_clr;
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    rd_data <= rd_en ? csr_mem[rd_addr] : 32'h0;
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
    end else if (pre_en) begin
      csr_mem[pre_addr] <= pre_data;
    end else if (wr_en) begin
      csr_mem[wr_addr] <= wr_data;
    end
  end

  // Reference CSR contents.
  logic [31:0] ref_mem [0:4095];

  typedef struct packed {
    logic        rdy;
    logic        re;
    logic [11:0] ra;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rd;
    logic        ri;
    logic        dv;
    logic [31:0] dpc;
    logic        mt;
    logic        mr;
  } obs_t;

  obs_t cur;
  obs_t idle;
  assign cur = {req_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, resp_valid, resp_data,
                resp_illegal, redirect_valid, redirect_pc, mtrap, mret};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input obs_t g, input obs_t x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, g, x);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] g, input logic [31:0] x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, g, x);
    end
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    ref_mem[a] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issues one request, checks every cycle until the controller is idle again,
  // and reports the key values seen on the outputs.
  task automatic run_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] opd,
                         input logic sup, input logic [31:0] pc, input logic [31:0] cause,
                         input logic [31:0] tval, input string nm,
                         output logic [31:0] g_resp, output logic g_ill, output int g_wc,
                         output logic [31:0] g_wd, output logic [31:0] g_dpc);
    obs_t e [0:5];
    int n;
    logic [31:0] r, nv, m, tgt;
    logic wr, ill;
    for (int k = 0; k < 6; k++) e[k] = '0;
    n = 2;
    if (op inside {3'd1, 3'd2, 3'd3}) begin
      r   = ref_mem[a];
      wr  = (op == 3'd1) || !sup;
      ill = ROC && (a[11:10] == 2'b11) && wr;
      nv  = (op == 3'd1) ? opd : (op == 3'd2) ? (r | opd) : (r & ~opd);
      e[1].re = 1'b1; e[1].ra = a;
      e[2].rv = 1'b1; e[2].ri = ill; e[2].rd = ill ? 32'h0 : r;
      if (wr && !ill) begin
        e[2].we = 1'b1; e[2].wa = a; e[2].wd = nv;
        ref_mem[a] = nv;
      end
    end else if (op == 3'd4) begin
      m   = ref_mem[12'h305];
      tgt = m - (m % 4);
      if (VEC && (m % 4 == 1) && cause[31]) tgt = tgt + (cause % 32'h8000_0000) * 4;
      e[1].we = 1'b1; e[1].wa = 12'h341; e[1].wd = pc - (pc % 4);
      e[2].we = 1'b1; e[2].wa = 12'h342; e[2].wd = cause;
      e[3].we = 1'b1; e[3].wa = 12'h343; e[3].wd = tval;
      e[3].re = 1'b1; e[3].ra = 12'h305;
      e[4].mt = 1'b1; e[4].dv = 1'b1; e[4].dpc = tgt;
      ref_mem[12'h341] = pc - (pc % 4);
      ref_mem[12'h342] = cause;
      ref_mem[12'h343] = tval;
      n = 4;
    end else if (op == 3'd5) begin
      e[1].re = 1'b1; e[1].ra = 12'h341;
      e[2].mr = 1'b1; e[2].dv = 1'b1; e[2].dpc = ref_mem[12'h341] - (ref_mem[12'h341] % 4);
    end else begin
      e[2].rv = 1'b1; e[2].ri = 1'b1;
    end
    e[0].rdy = 1'b1;
    e[n+1].rdy = 1'b1;
    g_resp = '0; g_ill = 1'b0; g_wc = 0; g_wd = '0; g_dpc = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_operand = opd;
    req_wr_suppress = sup; req_pc = pc; req_cause = cause; req_tval = tval;
    chk($sformatf("%s/c0", nm), cur, e[0]);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("%s/c%0d", nm, k), cur, e[k]);
      if (resp_valid) begin g_resp = resp_data; g_ill = resp_illegal; end
      if (wr_en) begin g_wc++; g_wd = wr_data; end
      if (redirect_valid) g_dpc = redirect_pc;
    end
  endtask

  typedef struct {
    logic [11:0] pa;
    logic [31:0] pv;
    logic [2:0]  op;
    logic [11:0] a;
    logic [31:0] opd;
    logic        sup;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] x_resp;
    logic        x_ill;
    int          x_wc;
    logic [31:0] x_wd;
    logic [31:0] x_dpc;
  } vec_t;

  vec_t tv [9];

  initial begin
    logic [31:0] g_resp, g_wd, g_dpc;
    logic        g_ill;
    int          g_wc;
    logic [11:0] addrs [8];
    logic [11:0] ra;
    logic [2:0]  rop;
    obs_t        e;

    idle = '0;
    idle.rdy = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    addrs = '{12'h340, 12'h300, 12'hC00, 12'hC80, 12'h305, 12'h341, 12'h7C0, 12'h000};

    tv[0] = '{12'h340, 32'h12345678, 3'd1, 12'h340, 32'hDEADBEEF, 1'b0, 0, 0, 0,
              32'h12345678, 1'b0, 1, 32'hDEADBEEF, 0};
    tv[1] = '{12'h300, 32'h80, 3'd2, 12'h300, 32'h8, 1'b0, 0, 0, 0,
              32'h80, 1'b0, 1, 32'h88, 0};
    tv[2] = '{12'h300, 32'h80, 3'd3, 12'h300, 32'h80, 1'b1, 0, 0, 0,
              32'h80, 1'b0, 0, 0, 0};
    tv[3] = '{12'hC00, 32'h1234, 3'd1, 12'hC00, 32'h5, 1'b0, 0, 0, 0,
              32'h0, 1'b1, 0, 0, 0};
    tv[4] = '{12'hC00, 32'h1234, 3'd2, 12'hC00, 32'h0, 1'b1, 0, 0, 0,
              32'h1234, 1'b0, 0, 0, 0};
    tv[5] = '{12'h340, 32'h1, 3'd7, 12'h340, 32'hFF, 1'b0, 0, 0, 0,
              32'h0, 1'b1, 0, 0, 0};
    tv[6] = '{12'h305, 32'h100, 3'd4, 12'h000, 32'h0, 1'b0, 32'h1003, 32'h2, 32'hABC,
              32'h0, 1'b0, 3, 32'hABC, 32'h100};
    tv[7] = '{12'h305, 32'h101, 3'd4, 12'h000, 32'h0, 1'b0, 32'h1003, 32'h80000007, 32'h55,
              32'h0, 1'b0, 3, 32'h55, VEC ? 32'h11C : 32'h100};
    tv[8] = '{12'h341, 32'h2004, 3'd5, 12'h000, 32'h0, 1'b0, 0, 0, 0,
              32'h0, 1'b0, 0, 0, 32'h2004};

    reset = 1'b1; mem_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_operand = '0;
    req_wr_suppress = 1'b0; req_pc = '0; req_cause = '0; req_tval = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", cur, idle);
    reset = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      preset(tv[i].pa, tv[i].pv);
      run_req(tv[i].op, tv[i].a, tv[i].opd, tv[i].sup, tv[i].pc, tv[i].cause, tv[i].tval,
              $sformatf("vec%0d", i), g_resp, g_ill, g_wc, g_wd, g_dpc);
      chk_val($sformatf("vec%0d_resp", i), g_resp, tv[i].x_resp);
      chk_val($sformatf("vec%0d_ill", i), 32'(g_ill), 32'(tv[i].x_ill));
      chk_val($sformatf("vec%0d_wcount", i), 32'(g_wc), 32'(tv[i].x_wc));
      chk_val($sformatf("vec%0d_wdata", i), g_wd, tv[i].x_wd);
      chk_val($sformatf("vec%0d_redirect", i), g_dpc, tv[i].x_dpc);
    end

    // Reset while in TRAP_CAUSE: earlier writes stay, nothing else happens.
    preset(12'h305, 32'h200);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_pc = 32'h3006; req_cause = 32'h5; req_tval = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    e = '0; e.we = 1'b1; e.wa = 12'h341; e.wd = 32'h3004;
    chk("rst_epc", cur, e);
    @(negedge clk);
    e.wa = 12'h342; e.wd = 32'h5;
    chk("rst_cause", cur, e);
    reset = 1'b1;
    ref_mem[12'h341] = 32'h3004;
    ref_mem[12'h342] = 32'h5;
    @(negedge clk);
    chk("rst_idle", cur, idle);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet%0d", k), cur, idle);
    end
    chk_val("rst_mcause_kept", csr_mem[12'h342], 32'h5);

    // Valid held high: one acceptance every third cycle, busy-time field
    // changes must not leak into the in-flight op.
    preset(12'h340, 32'hCAFE0001);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      req_valid = 1'b1;
      if (k % 3 == 0) begin
        req_op = 3'd2; req_addr = 12'h340; req_operand = $urandom; req_wr_suppress = 1'b1;
      end else begin
        req_op = 3'($urandom_range(0, 7)); req_addr = 12'($urandom);
        req_operand = $urandom; req_wr_suppress = 1'($urandom_range(0, 1));
        req_pc = $urandom; req_cause = $urandom; req_tval = $urandom;
      end
      chk_val($sformatf("b2b_ready%0d", k), 32'(req_ready), 32'(k % 3 == 0));
      chk_val($sformatf("b2b_rvalid%0d", k), 32'(resp_valid), 32'(k % 3 == 2));
      chk_val($sformatf("b2b_wen%0d", k), 32'(wr_en), 32'h0);
      if (k % 3 == 2) chk_val($sformatf("b2b_rdata%0d", k), resp_data, ref_mem[12'h340]);
      @(negedge clk);
    end
    req_valid = 1'b0;

    // Randomized requests against the reference model.
    for (int it = 0; it < 80; it++) begin
      int idx;
      idx = $urandom_range(0, 7);
      ra  = (idx == 7) ? 12'($urandom) : addrs[idx];
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd4 && $urandom_range(0, 1) == 1) preset(12'h305, $urandom);
      run_req(rop, ra, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $sformatf("rnd%0d", it), g_resp, g_ill, g_wc, g_wd, g_dpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
